// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module : shift_pkg
// Brief  : Shared types for the multi-cycle shifter: op codes, FSM states,
//          and a ceil-log2 helper used to size shift-amount and step fields.
// Rev    : 1.0  initial release
// ============================================================================
package shift_pkg;

  // Operation select as presented on the op port
  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Smallest r with 2**r >= value (0 for value <= 1)
  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
// Module : shift_stage
// Brief  : One log-shifter stage. When enabled, moves the word by DIST bit
//          positions in the direction/fill selected by op; otherwise passes
//          the word through unchanged.
// Rev    : 1.0  initial release
// ============================================================================
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             en,
  input  op_e              op,
  input  logic             sign,
  output logic [WIDTH-1:0] data_out
);

  // Select the shifted or pass-through word; DIST is always below WIDTH
  always_comb begin
    data_out = data_in;
    if (en) begin
      case (op)
        OP_SLL:  data_out = {data_in[WIDTH-DIST-1:0], {DIST{1'b0}}};
        OP_SRL:  data_out = {{DIST{1'b0}}, data_in[WIDTH-1:DIST]};
        OP_SRA:  data_out = {{DIST{sign}}, data_in[WIDTH-1:DIST]};
        OP_ROR:  data_out = {data_in[DIST-1:0], data_in[WIDTH-1:DIST]};
        default: data_out = data_in;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_unit_seq.sv
`default_nettype none
// ============================================================================
// Module : shift_unit_seq
// Brief  : Multi-cycle SLL/SRL/SRA/ROR shifter with valid/ready handshakes.
//          A chain of log-shifter stages is evaluated a group of
//          BITS_PER_CYCLE stages per clock, so latency is a constant NSTEPS
//          cycles from accept to out_valid regardless of the amount.
// Rev    : 1.0  initial release
// ============================================================================
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int SAT_AMOUNT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z
);

  localparam int SHAMT_W = log2_ceil(WIDTH);
  localparam int NSTEPS  = (SHAMT_W + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam int STEP_W  = (NSTEPS > 1) ? log2_ceil(NSTEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEPS - 1);

  state_e               state;
  state_e               state_next;
  logic [WIDTH-1:0]     data;
  logic [SHAMT_W-1:0]   amount;
  op_e                  op_q;
  logic                 sign;
  logic [STEP_W-1:0]    step;

  logic                 accept;
  logic                 last_step;
  logic                 over_range;
  logic                 sat_hit;
  logic [WIDTH-1:0]     load_data;
  logic [SHAMT_W-1:0]   load_amount;
  logic [SHAMT_W:0][WIDTH-1:0] stage_data;

  // Handshake outputs decode straight from state; no input-to-output path
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // flush in IDLE blocks acceptance
  assign accept    = in_valid && (state == IDLE) && !flush;
  assign last_step = (step == LAST_STEP);

  // Work out the operand and amount to load; saturated amounts preload the
  // final result and run the stages with a zero amount to keep latency fixed
  always_comb begin
    over_range  = |b[WIDTH-1:SHAMT_W];
    sat_hit     = (SAT_AMOUNT != 0) && over_range && (op_e'(op) != OP_ROR);
    load_data   = a;
    load_amount = b[SHAMT_W-1:0];
    if (sat_hit) begin
      load_amount = '0;
      load_data   = (op_e'(op) == OP_SRA) ? {WIDTH{a[WIDTH-1]}} : '0;
    end
  end

  // Full stage chain; only the stages belonging to the current step group
  // are enabled, the rest pass data through
  assign stage_data[0] = data;
  for (genvar j = 0; j < SHAMT_W; j++) begin : g_stage
    logic stage_en;
    assign stage_en = amount[j] && (step == STEP_W'(j / BITS_PER_CYCLE));
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << j)
    ) u_stage (
      .data_in  (stage_data[j]),
      .en       (stage_en),
      .op       (op_q),
      .sign     (sign),
      .data_out (stage_data[j+1])
    );
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush has priority over every other input
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = SHIFT;
      end
      SHIFT: begin
        if (flush)          state_next = IDLE;
        else if (last_step) state_next = DONE;
      end
      DONE: begin
        if (flush || out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, advance one stage group per SHIFT
  // cycle, publish z on the final group; z is untouched by flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data   <= '0;
      amount <= '0;
      op_q   <= OP_SLL;
      sign   <= 1'b0;
      step   <= '0;
      z      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data   <= load_data;
            amount <= load_amount;
            op_q   <= op_e'(op);
            sign   <= a[WIDTH-1];
            step   <= '0;
          end
        end
        SHIFT: begin
          if (!flush) begin
            data <= stage_data[SHAMT_W];
            step <= step + 1'b1;
            if (last_step) begin
              z <= stage_data[SHAMT_W];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_unit_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_shift_unit_seq
// Brief  : Self-checking bench for shift_unit_seq. Four instances (1, 1 with
//          saturation, 2 and 5 bits per cycle) share stimulus and are checked
//          against a plain-arithmetic reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_shift_unit_seq;
  import shift_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_mod;
    logic [31:0] exp_sat;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        out_ready;
  logic [3:0]  rdy;
  logic [3:0]  vld;
  logic [31:0] zz [4];

  int          lat [4];
  logic [31:0] last_z [4];
  int          checks;
  int          errors;
  vec_t        vt [16];

  shift_unit_seq #(.WIDTH(32), .BITS_PER_CYCLE(1), .SAT_AMOUNT(0)) dut_b1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .op(op), .a(a), .b(b),
    .flush(flush), .out_valid(vld[0]), .out_ready(out_ready), .z(zz[0]));
  shift_unit_seq #(.WIDTH(32), .BITS_PER_CYCLE(1), .SAT_AMOUNT(1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .op(op), .a(a), .b(b),
    .flush(flush), .out_valid(vld[1]), .out_ready(out_ready), .z(zz[1]));
  shift_unit_seq #(.WIDTH(32), .BITS_PER_CYCLE(2), .SAT_AMOUNT(0)) dut_b2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .op(op), .a(a), .b(b),
    .flush(flush), .out_valid(vld[2]), .out_ready(out_ready), .z(zz[2]));
  shift_unit_seq #(.WIDTH(32), .BITS_PER_CYCLE(5), .SAT_AMOUNT(0)) dut_b5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]), .op(op), .a(a), .b(b),
    .flush(flush), .out_valid(vld[3]), .out_ready(out_ready), .z(zz[3]));

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a sequence ever stalls
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  // Reference: result from the mode definitions with plain arithmetic
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] av,
                                        input logic [31:0] bv, input bit sat);
    int          amt;
    logic [63:0] dbl;
    if (sat && (bv >= 32) && (o != OP_ROR))
      return (o == OP_SRA && av[31]) ? 32'hFFFF_FFFF : 32'h0;
    amt = int'(bv % 32);
    case (o)
      OP_SLL:  return av << amt;
      OP_SRL:  return av >> amt;
      OP_SRA:  return 32'($signed(av) >>> amt);
      default: begin
        dbl = {av, av} >> amt;
        return dbl[31:0];
      end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Issue one op to all instances, follow each through its latency while
  // garbage stays on the inputs, hold DONE with out_ready low, then release
  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] em, input logic [31:0] es, input string nm);
    logic [31:0] ex [4];
    ex[0] = em; ex[1] = es; ex[2] = em; ex[3] = em;
    @(negedge clk);
    chk({nm, " in_ready idle"}, 32'(rdy), 32'hF);
    in_valid = 1'b1; op = o; a = av; b = bv; out_ready = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      a  = $urandom;
      b  = $urandom;
      op = 2'($urandom_range(3));
      @(posedge clk);
      #1;
      chk($sformatf("%s in_ready busy c%0d", nm, c), 32'(rdy), 32'h0);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("%s dut%0d out_valid c%0d", nm, i, c), 32'(vld[i]), 32'(c >= lat[i]));
        if (c == lat[i] || c == 8)
          chk($sformatf("%s dut%0d z c%0d", nm, i, c), zz[i], ex[i]);
      end
    end
    // in_valid still high on the release edge must not be accepted
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({nm, " in_ready after release"}, 32'(rdy), 32'hF);
    chk({nm, " out_valid after release"}, 32'(vld), 32'h0);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    for (int i = 0; i < 4; i++) last_z[i] = ex[i];
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  ro;
    logic [31:0] newz;

    checks = 0;
    errors = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    op = 2'b00; a = '0; b = '0;
    lat[0] = 5; lat[1] = 5; lat[2] = 3; lat[3] = 1;

    vt[0]  = '{OP_SRA, 32'hF000_0000, 32'h0000_0004, 32'hFF00_0000, 32'hFF00_0000};
    vt[1]  = '{OP_SRL, 32'hF000_0000, 32'h0000_0004, 32'h0F00_0000, 32'h0F00_0000};
    vt[2]  = '{OP_SLL, 32'h0000_00F0, 32'h0000_0002, 32'h0000_03C0, 32'h0000_03C0};
    vt[3]  = '{OP_ROR, 32'h0000_000F, 32'h0000_0004, 32'hF000_0000, 32'hF000_0000};
    vt[4]  = '{OP_SRA, 32'h00FF_F000, 32'h0000_0003, 32'h001F_FE00, 32'h001F_FE00};
    vt[5]  = '{OP_SRA, 32'hF000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vt[6]  = '{OP_SRL, 32'h00FF_F000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vt[7]  = '{OP_SRA, 32'h8000_0001, 32'h0000_0020, 32'h8000_0001, 32'hFFFF_FFFF};
    vt[8]  = '{OP_SRA, 32'h7FFF_FFFF, 32'h0000_0020, 32'h7FFF_FFFF, 32'h0000_0000};
    vt[9]  = '{OP_SLL, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 32'h0000_0000};
    vt[10] = '{OP_ROR, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 32'h1234_5678};
    vt[11] = '{OP_SRA, 32'hF000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vt[12] = '{OP_ROR, 32'h8000_0001, 32'h0000_0001, 32'hC000_0000, 32'hC000_0000};
    vt[13] = '{OP_SLL, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32'h8000_0000};
    vt[14] = '{OP_SRL, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000};
    vt[15] = '{OP_ROR, 32'h1234_5678, 32'h0000_0024, 32'h8123_4567, 32'h8123_4567};

    // Reset state, sampled while reset is held and just after release
    #12;
    chk("reset in_ready", 32'(rdy), 32'hF);
    chk("reset out_valid", 32'(vld), 32'h0);
    for (int i = 0; i < 4; i++) chk($sformatf("reset dut%0d z", i), zz[i], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset in_ready", 32'(rdy), 32'hF);
    chk("post-reset out_valid", 32'(vld), 32'h0);

    // Directed vectors
    for (int k = 0; k < 16; k++)
      run_op(vt[k].op, vt[k].a, vt[k].b, vt[k].exp_mod, vt[k].exp_sat, $sformatf("vec%0d", k));

    // Flush at step 2 of the 1-bit instances: they never raise out_valid
    newz = model(OP_SRA, 32'hF000_0000, 32'd4, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; op = OP_SRA; a = 32'hF000_0000; b = 32'd4;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("flush pre c%0d out_valid b1", c), 32'(vld[0]), 32'h0);
      if (c < 2) @(negedge clk);
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush in_ready", 32'(rdy), 32'hF);
    chk("flush out_valid", 32'(vld), 32'h0);
    for (int i = 0; i < 4; i++) begin
      last_z[i] = (lat[i] < 3) ? newz : last_z[i];
      chk($sformatf("flush dut%0d z", i), zz[i], last_z[i]);
    end
    @(negedge clk);
    flush = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("flush after c%0d out_valid", c), 32'(vld), 32'h0);
    end

    // flush together with out_ready in DONE: single IDLE return, no repeat
    @(negedge clk);
    in_valid = 1'b1; op = OP_SLL; a = 32'h0000_00F0; b = 32'd2;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("flush+ready pre out_valid", 32'(vld), 32'hF);
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("flush+ready in_ready", 32'(rdy), 32'hF);
    chk("flush+ready out_valid", 32'(vld), 32'h0);
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("flush+ready no duplicate", 32'(vld), 32'h0);
    for (int i = 0; i < 4; i++) begin
      last_z[i] = 32'h0000_03C0;
      chk($sformatf("flush+ready dut%0d z", i), zz[i], last_z[i]);
    end

    // flush in IDLE suppresses acceptance
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = OP_SRL; a = 32'hFFFF_FFFF; b = 32'd1;
    @(posedge clk);
    #1;
    chk("idle flush in_ready", 32'(rdy), 32'hF);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("idle flush out_valid", 32'(vld), 32'h0);

    // Sweep of SRA amounts
    for (int bb = 0; bb < 32; bb++)
      run_op(OP_SRA, 32'hF000_0000, 32'(bb), model(OP_SRA, 32'hF000_0000, 32'(bb), 1'b0),
             model(OP_SRA, 32'hF000_0000, 32'(bb), 1'b1), $sformatf("sweep%0d", bb));

    // Random ops against the model
    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(3));
      ra = $urandom;
      rb = ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(40));
      run_op(ro, ra, rb, model(ro, ra, rb, 1'b0), model(ro, ra, rb, 1'b1),
             $sformatf("rand%0d", n));
    end

    // Asynchronous reset between edges while shifting (and DONE for 5-bit)
    @(negedge clk);
    in_valid = 1'b1; op = OP_SRA; a = 32'hF000_0000; b = 32'd4;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst in_ready", 32'(rdy), 32'hF);
    chk("async rst out_valid", 32'(vld), 32'h0);
    for (int i = 0; i < 4; i++) chk($sformatf("async rst dut%0d z", i), zz[i], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(OP_ROR, 32'h0000_000F, 32'd4, 32'hF000_0000, 32'hF000_0000, "after rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
